// File: rtl/sb_cfg_loader_pkg.sv
// sb_cfg_pkg: shared definitions for the switch-block configuration loader.
//   - geometry of the target tile (memories, bits per memory, address widths)
//   - loader state enum
//   - CRC-8 polynomial constant
//   - sb_cfg_pack_addr(): (bit select, memory index) -> tile address
// Optional feature macro: SB_CFG_LOADER_CRC_EN adds the CHECK state.
package sb_cfg_pkg;

  localparam int NUM_MEMS     = 18;
  localparam int BITS_PER_MEM = 2;
  localparam int MEM_AW       = $clog2(NUM_MEMS);
  localparam int BIT_AW       = (BITS_PER_MEM > 1) ? $clog2(BITS_PER_MEM) : 1;
  localparam int ADDR_W       = BIT_AW + MEM_AW;
  localparam int TOTAL_BITS   = NUM_MEMS * BITS_PER_MEM;

  localparam logic [7:0] SB_CFG_CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
`ifdef SB_CFG_LOADER_CRC_EN
    , ST_CHECK
`endif
  } state_e;

  // Tile address is ascending-indexed: bit select occupies the leftmost
  // field, followed by the memory index MSB first.
  function automatic logic [0:ADDR_W-1] sb_cfg_pack_addr(
    input logic [BIT_AW-1:0] bit_sel,
    input logic [MEM_AW-1:0] mem_idx
  );
    return {bit_sel, mem_idx};
  endfunction

endpackage

// File: rtl/sb_cfg_loader_if.sv
// sb_cfg_loader_if: bitstream handshake, control and tile-programming bus
// of the configuration loader.
//   master : bitstream source / controller (drives start, abort, bs_*)
//   slave  : the loader (drives bs_ready, enable, address, data_in,
//            busy, done, crc_err)
interface sb_cfg_loader_if;
  import sb_cfg_pkg::*;

  logic              start;
  logic              abort;
  logic              bs_valid;
  logic              bs_data;
  logic              bs_ready;
  logic              enable;
  logic [0:ADDR_W-1] address;
  logic              data_in;
  logic              busy;
  logic              done;
  logic              crc_err;

  modport master (
    output start, abort, bs_valid, bs_data,
    input  bs_ready, enable, address, data_in, busy, done, crc_err
  );

  modport slave (
    input  start, abort, bs_valid, bs_data,
    output bs_ready, enable, address, data_in, busy, done, crc_err
  );
endinterface

// File: rtl/sb_cfg_loader_crc8.sv
// sb_cfg_crc8: serial CRC-8 (polynomial SB_CFG_CRC_POLY, init 0x00),
// one message bit per step, MSB-first stream order.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : reset the remainder to 0x00 (wins over step_i)
//   step_i     : fold bit_i into the remainder this cycle
//   bit_i      : message bit
//   crc_o      : current remainder
// Only compiled when SB_CFG_LOADER_CRC_EN is defined; the loader has no
// CRC logic otherwise.
`ifdef SB_CFG_LOADER_CRC_EN
module sb_cfg_crc8
  import sb_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       step_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[7] ^ bit_i;
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = 8'h00;
    end else if (step_i) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (fb ? SB_CFG_CRC_POLY : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 8'h00;
    else        crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule
`endif

// File: rtl/sb_cfg_loader.sv
// sb_cfg_loader: sequences a serial configuration bitstream into the
// decoder-addressed mux memories of one switch block. Each bit is fetched
// over a valid/ready handshake, then written with SETUP / STROBE / HOLD
// phases around a single-cycle enable pulse.
// Ports:
//   prog_clk     : programming clock (rising edge)
//   prog_reset_n : asynchronous active-low reset
//   cfg (slave)  : start/abort control, bs_valid/bs_data/bs_ready stream,
//                  enable/address/data_in tile bus, busy/done/crc_err status
// Optional feature macro: SB_CFG_LOADER_CRC_EN -- after the data bits an
// 8-bit CRC-8 is received and compared; a mismatch sets sticky crc_err.
module sb_cfg_loader
  import sb_cfg_pkg::*;
(
  input  logic           prog_clk,
  input  logic           prog_reset_n,
  sb_cfg_loader_if.slave cfg
);

  state_e            state_q, state_d;
  logic [BIT_AW-1:0] bit_q, bit_d;
  logic [MEM_AW-1:0] mem_q, mem_d;
  logic [0:ADDR_W-1] addr_q, addr_d;
  logic              data_q, data_d;
  logic              enable_q, done_q, busy_q;
  logic              bit_wrap, last_bit;

`ifdef SB_CFG_LOADER_CRC_EN
  logic [7:0] rx_q, rx_d;
  logic [2:0] chk_q, chk_d;
  logic       crc_err_q, crc_err_d;
  logic       crc_clr, crc_step;
  logic [7:0] crc_val;

  sb_cfg_crc8 u_crc (
    .clk    (prog_clk),
    .rst_n  (prog_reset_n),
    .clr_i  (crc_clr),
    .step_i (crc_step),
    .bit_i  (cfg.bs_data),
    .crc_o  (crc_val)
  );
`endif

  assign bit_wrap = (bit_q == BIT_AW'(BITS_PER_MEM - 1));
  assign last_bit = bit_wrap && (mem_q == MEM_AW'(NUM_MEMS - 1));

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    mem_d   = mem_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef SB_CFG_LOADER_CRC_EN
    rx_d      = rx_q;
    chk_d     = chk_q;
    crc_err_d = crc_err_q;
    crc_clr   = 1'b0;
    crc_step  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cfg.start) begin
          bit_d   = '0;
          mem_d   = '0;
          state_d = ST_FETCH;
`ifdef SB_CFG_LOADER_CRC_EN
          crc_err_d = 1'b0;
          crc_clr   = 1'b1;
          chk_d     = '0;
`endif
        end
      end
      ST_FETCH: begin
        if (cfg.bs_valid) begin
          // Only edge where the tile bus changes, so address/data_in are
          // stable through SETUP, STROBE and HOLD.
          data_d  = cfg.bs_data;
          addr_d  = sb_cfg_pack_addr(bit_q, mem_q);
          state_d = ST_SETUP;
`ifdef SB_CFG_LOADER_CRC_EN
          crc_step = 1'b1;
`endif
        end
      end
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (last_bit) begin
          // Counters return to 0 rather than stepping to an undecoded index.
          bit_d = '0;
          mem_d = '0;
`ifdef SB_CFG_LOADER_CRC_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else if (bit_wrap) begin
          bit_d   = '0;
          mem_d   = mem_q + 1'b1;
          state_d = ST_FETCH;
        end else begin
          bit_d   = bit_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
`ifdef SB_CFG_LOADER_CRC_EN
      ST_CHECK: begin
        if (cfg.bs_valid) begin
          rx_d  = {rx_q[6:0], cfg.bs_data};
          chk_d = chk_q + 3'd1;
          if (chk_q == 3'd7) begin
            crc_err_d = (rx_d != crc_val);
            state_d   = ST_DONE;
          end
        end
      end
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (cfg.abort) state_d = ST_IDLE;
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe; abort therefore drops enable on the next edge.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      mem_q    <= '0;
      addr_q   <= '0;
      data_q   <= 1'b0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SB_CFG_LOADER_CRC_EN
      rx_q      <= 8'h00;
      chk_q     <= '0;
      crc_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      mem_q    <= mem_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      enable_q <= (state_d == ST_STROBE);
      done_q   <= (state_d == ST_DONE);
      busy_q   <= (state_d != ST_IDLE);
`ifdef SB_CFG_LOADER_CRC_EN
      rx_q      <= rx_d;
      chk_q     <= chk_d;
      crc_err_q <= crc_err_d;
`endif
    end
  end

  assign cfg.enable  = enable_q;
  assign cfg.address = addr_q;
  assign cfg.data_in = data_q;
  assign cfg.done    = done_q;
  assign cfg.busy    = busy_q;
`ifdef SB_CFG_LOADER_CRC_EN
  assign cfg.bs_ready = (state_q == ST_FETCH) || (state_q == ST_CHECK);
  assign cfg.crc_err  = crc_err_q;
`else
  assign cfg.bs_ready = (state_q == ST_FETCH);
  assign cfg.crc_err  = 1'b0;
`endif

endmodule

// File: tb/tb_sb_cfg_loader.sv
// Testbench for sb_cfg_loader. Expected tile writes, completion cycle and
// CRC outcome come from a reference model built from the load rules:
// pulse k writes bit k to address {k%2, k/2}; done lands in cycle
// 146 + stall cycles (+8 with SB_CFG_LOADER_CRC_EN), counting the start
// cycle as cycle 1; the CRC is a polynomial long division of the data.
module tb_sb_cfg_loader;
  import sb_cfg_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sb_cfg_loader_if ifc();

  sb_cfg_loader dut (
    .prog_clk     (clk),
    .prog_reset_n (rst_n),
    .cfg          (ifc)
  );

  int n_chk  = 0;
  int n_fail = 0;

`ifdef SB_CFG_LOADER_CRC_EN
  localparam int NSTREAM = 44;
  localparam int EXTRA   = 8;
`else
  localparam int NSTREAM = 36;
  localparam int EXTRA   = 0;
`endif

  logic       dbits [36];
  logic [7:0] crc_byte;
  int         stall [NSTREAM];

  // Bitstream source: stall[k] counts cycles of bs_valid low while the
  // loader is waiting for bit k.
  bit drv_on = 0, drv_was = 0, hs_pending = 0;
  int idx = 0, stall_left = 0;
  always @(negedge clk) begin
    if (drv_on) begin
      if (!drv_was) begin
        idx = 0; stall_left = stall[0]; hs_pending = 0;
      end
      if (hs_pending) begin
        idx++;
        hs_pending = 0;
        if (idx < NSTREAM) stall_left = stall[idx];
      end
      if (idx < NSTREAM) begin
        if (idx < 36) ifc.bs_data = dbits[idx];
        else          ifc.bs_data = crc_byte[7-(idx-36)];
        if (ifc.bs_ready && stall_left > 0) begin
          ifc.bs_valid = 1'b0;
          stall_left--;
        end else begin
          ifc.bs_valid = 1'b1;
        end
        hs_pending = ifc.bs_valid && ifc.bs_ready;
      end else begin
        ifc.bs_valid = 1'b0;
      end
    end else begin
      ifc.bs_valid = 1'b0;
      ifc.bs_data  = 1'b0;
    end
    drv_was = drv_on;
  end

  // Tile-side monitor.
  bit         mon_on = 0, mon_was = 0;
  int         cyc = 0, done_cyc = 0, done_cnt = 0, multi = 0, sh_err = 0;
  logic [5:0] p_addr [$];
  logic       p_data [$];
  logic [5:0] prev_addr;
  logic       prev_data, prev_en;
  always @(negedge clk) begin
    if (mon_on) begin
      if (!mon_was) begin
        cyc = 0; done_cyc = 0; done_cnt = 0; multi = 0; sh_err = 0;
        p_addr.delete(); p_data.delete();
        prev_en = 1'b0; prev_addr = ifc.address; prev_data = ifc.data_in;
      end
      cyc++;
      if (ifc.enable) begin
        p_addr.push_back(ifc.address);
        p_data.push_back(ifc.data_in);
        if (prev_en) multi++;
        if (ifc.address !== prev_addr || ifc.data_in !== prev_data) sh_err++;
      end
      if (prev_en && (ifc.address !== prev_addr || ifc.data_in !== prev_data)) sh_err++;
      if (ifc.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      prev_en   = ifc.enable;
      prev_addr = ifc.address;
      prev_data = ifc.data_in;
    end
    mon_was = mon_on;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] model_crc();
    logic [43:0] r;
    r = '0;
    for (int i = 0; i < 36; i++) r[43-i] = dbits[i];
    for (int i = 43; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  task automatic idle_gap();
    drv_on = 0; mon_on = 0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic zero_stalls();
    for (int i = 0; i < NSTREAM; i++) stall[i] = 0;
  endtask

  task automatic run_load(input string nm, input int start_at);
    int exp_done, budget;
    logic exp_err;
    exp_done = 146 + EXTRA;
    for (int i = 0; i < NSTREAM; i++) exp_done += stall[i];
`ifdef SB_CFG_LOADER_CRC_EN
    exp_err = (crc_byte != model_crc());
`else
    exp_err = 1'b0;
`endif
    idle_gap();
    ifc.start = 1'b1; drv_on = 1; mon_on = 1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    budget = 0;
    while (done_cnt == 0 && budget < 4000) begin
      ifc.start = (start_at > 0 && cyc == start_at - 1);
      @(posedge clk); #1;
      budget++;
    end
    ifc.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_chk++;
    if (budget >= 4000) begin
      n_fail++; $display("FAIL %s_timeout: no done within %0d cycles", nm, budget);
    end
    n_chk++;
    if (p_addr.size() !== 36) begin
      n_fail++; $display("FAIL %s_pulse_count: got %0d want 36", nm, p_addr.size());
    end
    for (int k = 0; k < 36; k++) begin
      if (k < p_addr.size()) begin
        n_chk++;
        if (p_addr[k] !== 6'((k % 2) * 32 + k / 2)) begin
          n_fail++; $display("FAIL %s_addr[%0d]: got %b want %b", nm, k, p_addr[k], 6'((k % 2) * 32 + k / 2));
        end
        n_chk++;
        if (p_data[k] !== dbits[k]) begin
          n_fail++; $display("FAIL %s_data[%0d]: got %b want %b", nm, k, p_data[k], dbits[k]);
        end
      end
    end
    n_chk++;
    if (done_cyc !== exp_done) begin
      n_fail++; $display("FAIL %s_done_cycle: got %0d want %0d", nm, done_cyc, exp_done);
    end
    n_chk++;
    if (done_cnt !== 1) begin
      n_fail++; $display("FAIL %s_done_width: got %0d cycles want 1", nm, done_cnt);
    end
    n_chk++;
    if (multi !== 0 || sh_err !== 0) begin
      n_fail++; $display("FAIL %s_strobe_timing: multi=%0d setup_hold=%0d want 0/0", nm, multi, sh_err);
    end
    n_chk++;
    if (ifc.crc_err !== exp_err) begin
      n_fail++; $display("FAIL %s_crc_err: got %b want %b", nm, ifc.crc_err, exp_err);
    end
    n_chk++;
    if (ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_after: got %b want 0", nm, ifc.busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (ifc.enable  !== 1'b0) begin n_fail++; $display("FAIL rst_enable: got %b want 0", ifc.enable); end
    n_chk++; if (ifc.address !== '0)   begin n_fail++; $display("FAIL rst_address: got %b want 0", ifc.address); end
    n_chk++; if (ifc.data_in !== 1'b0) begin n_fail++; $display("FAIL rst_data_in: got %b want 0", ifc.data_in); end
    n_chk++; if (ifc.bs_ready!== 1'b0) begin n_fail++; $display("FAIL rst_bs_ready: got %b want 0", ifc.bs_ready); end
    n_chk++; if (ifc.busy    !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", ifc.busy); end
    n_chk++; if (ifc.done    !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", ifc.done); end
    n_chk++; if (ifc.crc_err !== 1'b0) begin n_fail++; $display("FAIL rst_crc_err: got %b want 0", ifc.crc_err); end
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_chk++;
    if (ifc.busy !== 1'b0 || ifc.bs_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: busy=%b bs_ready=%b want 0/0", ifc.busy, ifc.bs_ready);
    end
  endtask

  task automatic set_good_crc();
    crc_byte = model_crc();
  endtask

  task automatic test_alternating();
    for (int k = 0; k < 36; k++) dbits[k] = (k % 2 == 0);
    zero_stalls(); set_good_crc();
    run_load("alt", 0);
    n_chk++;
    if (p_addr.size() == 36 && p_addr[35] !== 6'b110001) begin
      n_fail++; $display("FAIL alt_last_addr: got %b want 110001", p_addr[35]);
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 36; k++) dbits[k] = 1'($urandom_range(0, 1));
    zero_stalls(); stall[5] = 10; set_good_crc();
    run_load("stall", 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 36; k++) dbits[k] = 1'($urandom_range(0, 1));
      for (int k = 0; k < NSTREAM; k++) stall[k] = $urandom_range(0, 3);
      set_good_crc();
      run_load("rand", 0);
    end
  endtask

  task automatic test_start_ignored();
    for (int k = 0; k < 36; k++) dbits[k] = 1'($urandom_range(0, 1));
    zero_stalls(); set_good_crc();
    run_load("start_busy", 50);
  endtask

  task automatic test_abort_restart();
    int budget;
    bit found;
    for (int k = 0; k < 36; k++) dbits[k] = 1'($urandom_range(0, 1));
    zero_stalls(); set_good_crc();
    idle_gap();
    ifc.start = 1'b1; drv_on = 1; mon_on = 1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    found = 0; budget = 0;
    while (!found && budget < 1000) begin
      if (ifc.enable === 1'b1 && ifc.address === 6'd10) found = 1;
      else begin @(posedge clk); #1; budget++; end
    end
    n_chk++;
    if (!found) begin n_fail++; $display("FAIL abort_reach_bit20: got no strobe want strobe at address 001010"); end
    ifc.abort = 1'b1;
    @(posedge clk); #1;
    ifc.abort = 1'b0;
    n_chk++;
    if (ifc.enable !== 1'b0 || ifc.busy !== 1'b0 || ifc.bs_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: enable=%b busy=%b bs_ready=%b want 0/0/0", ifc.enable, ifc.busy, ifc.bs_ready);
    end
    repeat (20) begin @(posedge clk); #1; end
    n_chk++;
    if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt); end
    n_chk++;
    if (p_addr.size() !== 21) begin n_fail++; $display("FAIL abort_pulses: got %0d want 21", p_addr.size()); end
    run_load("restart", 0);
  endtask

  task automatic test_reset_mid_strobe();
    int budget;
    for (int k = 0; k < 36; k++) dbits[k] = 1'b1;
    zero_stalls(); set_good_crc();
    idle_gap();
    ifc.start = 1'b1; drv_on = 1; mon_on = 1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    budget = 0;
    while (!(ifc.enable === 1'b1 && ifc.address === 6'd33) && budget < 1000) begin
      @(posedge clk); #1; budget++;
    end
    n_chk++;
    if (budget >= 1000) begin n_fail++; $display("FAIL rststb_reach: got no strobe want strobe at address 100001"); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (ifc.enable !== 1'b0 || ifc.address !== '0 || ifc.data_in !== 1'b0 || ifc.bs_ready !== 1'b0 ||
        ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.crc_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rststb_async: en=%b addr=%b din=%b rdy=%b busy=%b done=%b crc=%b want all 0",
               ifc.enable, ifc.address, ifc.data_in, ifc.bs_ready, ifc.busy, ifc.done, ifc.crc_err);
    end
    drv_on = 0; mon_on = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_chk++;
    if (ifc.busy !== 1'b0 || ifc.bs_ready !== 1'b0 || ifc.enable !== 1'b0) begin
      n_fail++; $display("FAIL rststb_idle: busy=%b bs_ready=%b enable=%b want 0/0/0", ifc.busy, ifc.bs_ready, ifc.enable);
    end
  endtask

`ifdef SB_CFG_LOADER_CRC_EN
  task automatic test_crc();
    for (int k = 0; k < 36; k++) dbits[k] = 1'b0;
    zero_stalls();
    crc_byte = 8'h01;
    run_load("crc_bad", 0);
    crc_byte = 8'h00;
    run_load("crc_good", 0);
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    crc_byte = 8'h00;
    for (int k = 0; k < 36; k++) dbits[k] = 1'b0;
    zero_stalls();
    #1 rst_n = 1'b0;
    test_reset();
    test_alternating();
    test_stall();
    test_random();
    test_start_ignored();
    test_abort_restart();
`ifdef SB_CFG_LOADER_CRC_EN
    test_crc();
`endif
    test_reset_mid_strobe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
